// File: rtl/text_terminal_controller.sv
// -----------------------------------------------------------------------------
// text_terminal_controller
//
// Byte-stream terminal front end for a character cell buffer. ASCII bytes arrive
// over a valid/ready handshake. The controller tracks the cursor and interprets
// CR/LF/BS/FF. It drives the buffer's write port and its cursor overlay port.
// After reset and on form feed it sweeps every cell with CLEAR_CHAR, one cell per
// clock, in row-major order.
//
// Optional feature: define TERM_CTRL_TAB_EN to enable horizontal tab (0x09)
// handling. This advances the cursor to the next multiple of TAB_WIDTH. When the
// macro is not defined, TAB is ignored like any other non-printable byte.
//
// Ports
//   clk               : single clock
//   rst_n             : asynchronous active-low reset
//   in_valid/in_data  : input byte handshake (valid side)
//   in_ready          : controller accepts in_data this cycle
//   char_hpos/vpos    : buffer write cell
//   char_write_en     : buffer write strobe
//   char_symbol       : code to write
//   cursor_valid      : cursor position valid
//   cursor_display_en : enable cursor blink overlay
//   cursor_hpos/vpos  : cursor cell
//   busy              : clear sweep in progress
// All outputs are registered.
// -----------------------------------------------------------------------------
module text_terminal_controller #(
  parameter int         CHAR_HORZ_CNT = 16,
  parameter int         CHAR_VERT_CNT = 2,
  parameter int         CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int         CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
  parameter logic [7:0] CLEAR_CHAR    = 8'h20
`ifdef TERM_CTRL_TAB_EN
  ,
  parameter int         TAB_WIDTH     = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [CHAR_HORZ_W-1:0] char_hpos,
  output logic [CHAR_VERT_W-1:0] char_vpos,
  output logic                   char_write_en,
  output logic [7:0]             char_symbol,
  output logic                   cursor_valid,
  output logic                   cursor_display_en,
  output logic [CHAR_HORZ_W-1:0] cursor_hpos,
  output logic [CHAR_VERT_W-1:0] cursor_vpos,
  output logic                   busy
);

  localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [CHAR_HORZ_W-1:0] r_clr_h;
  logic [CHAR_VERT_W-1:0] r_clr_v;
  logic [CHAR_HORZ_W-1:0] r_cur_h;
  logic [CHAR_VERT_W-1:0] r_cur_v;
  logic                   r_in_ready;
  logic [CHAR_HORZ_W-1:0] r_char_hpos;
  logic [CHAR_VERT_W-1:0] r_char_vpos;
  logic                   r_char_write_en;
  logic [7:0]             r_char_symbol;
  logic                   r_cursor_valid;
  logic                   r_cursor_display_en;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_printable;
  logic [CHAR_VERT_W-1:0] w_row_next;
  logic [CHAR_HORZ_W-1:0] w_adv_h;
  logic [CHAR_VERT_W-1:0] w_adv_v;

  assign w_accept    = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  // Wrap by comparing against CNT-1 so non-power-of-2 screen sizes work.
  assign w_row_next = (r_cur_v == V_LAST) ? '0 : r_cur_v + 1'b1;

  // Cursor position after a printable byte: next column, or column 0 of the
  // next row (which itself wraps to row 0 -- there is no scrolling).
  always_comb begin
    w_adv_h = r_cur_h + 1'b1;
    w_adv_v = r_cur_v;
    if (r_cur_h == H_LAST) begin
      w_adv_h = '0;
      w_adv_v = w_row_next;
    end
  end

`ifdef TERM_CTRL_TAB_EN
  localparam logic [CHAR_HORZ_W:0] TAB_W_X = (CHAR_HORZ_W + 1)'(TAB_WIDTH);
  localparam logic [CHAR_HORZ_W:0] H_CNT_X = (CHAR_HORZ_W + 1)'(CHAR_HORZ_CNT);

  logic [CHAR_HORZ_W:0]   w_tab_col;
  logic [CHAR_HORZ_W-1:0] w_tab_h;
  logic [CHAR_VERT_W-1:0] w_tab_v;

  // Next tab stop, computed one bit wider so that a stop past the last column
  // is detectable and can wrap to the next line.
  always_comb begin
    w_tab_col = (({1'b0, r_cur_h} / TAB_W_X) + 1'b1) * TAB_W_X;
    w_tab_h   = w_tab_col[CHAR_HORZ_W-1:0];
    w_tab_v   = r_cur_v;
    if (w_tab_col >= H_CNT_X) begin
      w_tab_h = '0;
      w_tab_v = w_row_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= S_CLEAR;
      r_clr_h             <= '0;
      r_clr_v             <= '0;
      r_cur_h             <= '0;
      r_cur_v             <= '0;
      r_in_ready          <= 1'b0;
      r_char_hpos         <= '0;
      r_char_vpos         <= '0;
      r_char_write_en     <= 1'b0;
      r_char_symbol       <= '0;
      r_cursor_valid      <= 1'b0;
      r_cursor_display_en <= 1'b0;
      r_busy              <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_char_write_en     <= 1'b1;
          r_char_hpos         <= r_clr_h;
          r_char_vpos         <= r_clr_v;
          r_char_symbol       <= CLEAR_CHAR;
          r_busy              <= 1'b1;
          r_in_ready          <= 1'b0;
          r_cursor_valid      <= 1'b0;
          r_cursor_display_en <= 1'b0;
          r_cur_h             <= '0;
          r_cur_v             <= '0;
          if (r_clr_h == H_LAST) begin
            r_clr_h <= '0;
            if (r_clr_v == V_LAST) begin
              r_clr_v <= '0;
              r_state <= S_IDLE;
            end else begin
              r_clr_v <= r_clr_v + 1'b1;
            end
          end else begin
            r_clr_h <= r_clr_h + 1'b1;
          end
        end

        S_IDLE: begin
          r_char_write_en     <= 1'b0;
          r_busy              <= 1'b0;
          r_in_ready          <= 1'b1;
          r_cursor_valid      <= 1'b1;
          r_cursor_display_en <= 1'b1;
          if (w_accept) begin
            if (w_printable) begin
              r_char_write_en <= 1'b1;
              r_char_hpos     <= r_cur_h;
              r_char_vpos     <= r_cur_v;
              r_char_symbol   <= in_data;
              r_cur_h         <= w_adv_h;
              r_cur_v         <= w_adv_v;
            end else begin
              case (in_data)
                8'h0D: r_cur_h <= '0;
                8'h0A: r_cur_v <= w_row_next;
                8'h08: begin
                  // Backspace erases the cell it moves onto; at column 0 it is a no-op.
                  if (r_cur_h != '0) begin
                    r_cur_h         <= r_cur_h - 1'b1;
                    r_char_write_en <= 1'b1;
                    r_char_hpos     <= r_cur_h - 1'b1;
                    r_char_vpos     <= r_cur_v;
                    r_char_symbol   <= CLEAR_CHAR;
                  end
                end
                8'h0C: begin
                  // Drop ready right away so no byte is taken in the cycle
                  // before the sweep's first write.
                  r_state             <= S_CLEAR;
                  r_clr_h             <= '0;
                  r_clr_v             <= '0;
                  r_in_ready          <= 1'b0;
                  r_cursor_valid      <= 1'b0;
                  r_cursor_display_en <= 1'b0;
                  r_cur_h             <= '0;
                  r_cur_v             <= '0;
                end
`ifdef TERM_CTRL_TAB_EN
                8'h09: begin
                  r_cur_h <= w_tab_h;
                  r_cur_v <= w_tab_v;
                end
`endif
                default: ;
              endcase
            end
          end
        end

        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign in_ready          = r_in_ready;
  assign char_hpos         = r_char_hpos;
  assign char_vpos         = r_char_vpos;
  assign char_write_en     = r_char_write_en;
  assign char_symbol       = r_char_symbol;
  assign cursor_valid      = r_cursor_valid;
  assign cursor_display_en = r_cursor_display_en;
  assign cursor_hpos       = r_cur_h;
  assign cursor_vpos       = r_cur_v;
  assign busy              = r_busy;

endmodule

// File: tb/tb_text_terminal_controller.sv
module tb_text_terminal_controller;

  localparam int H  = 16;
  localparam int V  = 2;
  localparam int HW = $clog2(H);
  localparam int VW = $clog2(V);
  localparam int TW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [HW-1:0] char_hpos;
  logic [VW-1:0] char_vpos;
  logic          char_write_en;
  logic [7:0]    char_symbol;
  logic          cursor_valid;
  logic          cursor_display_en;
  logic [HW-1:0] cursor_hpos;
  logic [VW-1:0] cursor_vpos;
  logic          busy;

  text_terminal_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .char_hpos         (char_hpos),
    .char_vpos         (char_vpos),
    .char_write_en     (char_write_en),
    .char_symbol       (char_symbol),
    .cursor_valid      (cursor_valid),
    .cursor_display_en (cursor_display_en),
    .cursor_hpos       (cursor_hpos),
    .cursor_vpos       (cursor_vpos),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: cursor as (x,y), advance done on a linear cell index.
  int mx, my;
  int mwe, mh, mv, msym;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic void model_byte(input int b);
    int p;
    int t;
    mwe = 0;
    if (b >= 32 && b <= 126) begin
      mwe = 1; mh = mx; mv = my; msym = b;
      p = (my * H + mx + 1) % (H * V);
      mx = p % H; my = p / H;
    end else if (b == 13) begin
      mx = 0;
    end else if (b == 10) begin
      my = (my + 1) % V;
    end else if (b == 8) begin
      if (mx > 0) begin
        mx = mx - 1; mwe = 1; mh = mx; mv = my; msym = 32;
      end
`ifdef TERM_CTRL_TAB_EN
    end else if (b == 9) begin
      t = (mx / TW + 1) * TW;
      if (t >= H) begin
        mx = 0; my = (my + 1) % V;
      end else begin
        mx = t;
      end
`endif
    end
  endfunction

  task automatic check_model(input string nm);
    chk({nm, "_we"},   int'(char_write_en), mwe);
    chk({nm, "_hpos"}, int'(char_hpos),     mh);
    chk({nm, "_vpos"}, int'(char_vpos),     mv);
    chk({nm, "_sym"},  int'(char_symbol),   msym);
    chk({nm, "_curx"}, int'(cursor_hpos),   mx);
    chk({nm, "_cury"}, int'(cursor_vpos),   my);
    chk({nm, "_rdy"},  int'(in_ready),      1);
    chk({nm, "_busy"}, int'(busy),          0);
  endtask

  // Called at a negedge; drives one byte for one cycle and samples at the next negedge.
  task automatic apply(input logic [7:0] b, input string nm);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    @(negedge clk);
    model_byte(int'(b));
    check_model(nm);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mwe = 0;
    check_model("idle");
  endtask

  task automatic sweep_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("sweep_we",   int'(char_write_en), 1);
      chk("sweep_hpos", int'(char_hpos),     k % H);
      chk("sweep_vpos", int'(char_vpos),     k / H);
      chk("sweep_sym",  int'(char_symbol),   32);
      chk("sweep_busy", int'(busy),          1);
      chk("sweep_rdy",  int'(in_ready),      0);
      chk("sweep_cv",   int'(cursor_valid) + int'(cursor_display_en), 0);
    end
  endtask

  task automatic sweep_done();
    @(negedge clk);
    chk("done_rdy",  int'(in_ready),          1);
    chk("done_busy", int'(busy),              0);
    chk("done_cv",   int'(cursor_valid),      1);
    chk("done_de",   int'(cursor_display_en), 1);
    chk("done_we",   int'(char_write_en),     0);
    chk("done_curx", int'(cursor_hpos),       0);
    chk("done_cury", int'(cursor_vpos),       0);
    mx = 0; my = 0; mwe = 0; mh = H - 1; mv = V - 1; msym = 32;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_we"},   int'(char_write_en),     0);
    chk({nm, "_rdy"},  int'(in_ready),          0);
    chk({nm, "_busy"}, int'(busy),              0);
    chk({nm, "_cv"},   int'(cursor_valid),      0);
    chk({nm, "_de"},   int'(cursor_display_en), 0);
    chk({nm, "_pos"},  int'(char_hpos) + int'(char_vpos) + int'(char_symbol), 0);
    chk({nm, "_cur"},  int'(cursor_hpos) + int'(cursor_vpos), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    int         we;
    int         h;
    int         v;
    int         sym;
    int         cx;
    int         cy;
  } vec_t;

  vec_t vt[10];

  initial begin
    int r;
    logic [7:0] b;
    logic [7:0] ctl[9];
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    mx = 0; my = 0; mwe = 0; mh = 0; mv = 0; msym = 0;

    // Directed vectors from (0,0) after the power-on sweep.
    vt[0] = '{8'h41, 1, 0, 0, 8'h41, 1, 0};
    vt[1] = '{8'h42, 1, 1, 0, 8'h42, 2, 0};
    vt[2] = '{8'h43, 1, 2, 0, 8'h43, 3, 0};
    vt[3] = '{8'h08, 1, 2, 0, 8'h20, 2, 0};
    vt[4] = '{8'h0A, 0, 2, 0, 8'h20, 2, 1};
    vt[5] = '{8'h07, 0, 2, 0, 8'h20, 2, 1};
`ifdef TERM_CTRL_TAB_EN
    vt[6] = '{8'h09, 0, 2, 0, 8'h20, 8, 1};
`else
    vt[6] = '{8'h09, 0, 2, 0, 8'h20, 2, 1};
`endif
    vt[7] = '{8'h0D, 0, 2, 0, 8'h20, 0, 1};
    vt[8] = '{8'h08, 0, 2, 0, 8'h20, 0, 1};
    vt[9] = '{8'h5A, 1, 0, 1, 8'h5A, 1, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    sweep_cycles(H * V);
    sweep_done();

    // Table-driven directed vectors, back to back
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].b;
      @(posedge clk);
      @(negedge clk);
      model_byte(int'(vt[i].b));
      chk($sformatf("vec%0d_we", i),   int'(char_write_en), vt[i].we);
      chk($sformatf("vec%0d_hpos", i), int'(char_hpos),     vt[i].h);
      chk($sformatf("vec%0d_vpos", i), int'(char_vpos),     vt[i].v);
      chk($sformatf("vec%0d_sym", i),  int'(char_symbol),   vt[i].sym);
      chk($sformatf("vec%0d_curx", i), int'(cursor_hpos),   vt[i].cx);
      chk($sformatf("vec%0d_cury", i), int'(cursor_vpos),   vt[i].cy);
      chk($sformatf("vec%0d_rdy", i),  int'(in_ready),      1);
    end

    // Line and screen wrap: 16 bytes from (0,0) land on (0,1); 16 more on (0,0)
    apply(8'h0D, "cr");
    apply(8'h0A, "lf_wrap");
    for (int i = 0; i < H; i++) apply(8'h61 + 8'(i), "row0");
    chk("wrap1_last_h", int'(char_hpos), H - 1);
    chk("wrap1_last_v", int'(char_vpos), 0);
    chk("wrap1_curx",   int'(cursor_hpos), 0);
    chk("wrap1_cury",   int'(cursor_vpos), 1);
    for (int i = 0; i < H; i++) apply(8'h30 + 8'(i), "row1");
    chk("wrap2_last_h", int'(char_hpos), H - 1);
    chk("wrap2_last_v", int'(char_vpos), V - 1);
    chk("wrap2_curx",   int'(cursor_hpos), 0);
    chk("wrap2_cury",   int'(cursor_vpos), 0);

`ifdef TERM_CTRL_TAB_EN
    // Tab stops: (3,0)->(8,0); (12,0)->(0,1); (12,1)->(0,0)
    for (int i = 0; i < 3; i++) apply(8'h2E, "tabpos");
    apply(8'h09, "tab_a");
    chk("tab_a_x", int'(cursor_hpos), 8);
    for (int i = 0; i < 4; i++) apply(8'h2E, "tabpos");
    apply(8'h09, "tab_b");
    chk("tab_b_xy", int'(cursor_hpos) * 16 + int'(cursor_vpos), 1);
    for (int i = 0; i < 12; i++) apply(8'h2E, "tabpos");
    apply(8'h09, "tab_c");
    chk("tab_c_xy", int'(cursor_hpos) * 16 + int'(cursor_vpos), 0);
`endif

    // Randomised traffic with occasional idle gaps
    ctl = '{8'h0D, 8'h0A, 8'h08, 8'h07, 8'h09, 8'h00, 8'h7F, 8'hFF, 8'h1B};
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 11) begin
        idle_cycle();
      end else begin
        if (r < 6) b = 8'($urandom_range(32, 126));
        else       b = ctl[$urandom_range(0, 8)];
        apply(b, "rnd");
      end
    end
    in_valid = 1'b0;

    // Form feed at (7,1): ready drops next cycle, then a full sweep
    apply(8'h0D, "ffpos");
    if (my != 1) apply(8'h0A, "ffpos");
    for (int i = 0; i < 7; i++) apply(8'h2A, "ffpos");
    chk("ff_at_x", int'(cursor_hpos), 7);
    chk("ff_at_y", int'(cursor_vpos), 1);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ff_rdy",  int'(in_ready),      0);
    chk("ff_we",   int'(char_write_en), 0);
    chk("ff_cur",  int'(cursor_hpos) + int'(cursor_vpos), 0);
    chk("ff_cv",   int'(cursor_valid),  0);
    sweep_cycles(H * V);
    sweep_done();

    // Form feed again, reset pulse at sweep cycle 10 restarts the sweep
    apply(8'h45, "pre_ff2");
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ff2_rdy", int'(in_ready), 0);
    sweep_cycles(10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep_cycles(H * V);
    sweep_done();
    apply(8'h4F, "post_rst");
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
